// File: rtl/frame_pkg.sv
// Shared sizes, opcodes, command payload and FSM encoding for the snake frame RAM arbiter.
package frame_pkg;

   localparam int unsigned COLS = 60;
   localparam int unsigned ROWS = 64;
   localparam int unsigned AW   = 6;
   localparam int unsigned XW   = 6;

   localparam logic [1:0] OP_SET    = 2'b00;
   localparam logic [1:0] OP_CLR    = 2'b01;
   localparam logic [1:0] OP_TGL    = 2'b10;
   localparam logic [1:0] OP_CLRALL = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_CAP  = 3'd2,
      ST_WR   = 3'd3,
      ST_CLR  = 3'd4
   } state_t;

   typedef struct packed {
      logic [1:0]    op;
      logic [XW-1:0] x;
      logic [AW-1:0] y;
   } cmd_t;

endpackage

// File: rtl/row_bit_modify.sv
// Combinational single-cell update of one playfield row; an out-of-range index leaves the row untouched.
module row_bit_modify
   import frame_pkg::*;
(
   input  logic [COLS-1:0] row,
   input  logic [XW-1:0]   idx,
   input  logic [1:0]      op,
   output logic [COLS-1:0] new_row
);

   logic [COLS-1:0] mask;

   always_comb begin
      mask    = COLS'(1) << idx;
      new_row = row;
      case (op)
         OP_SET:  new_row = row | mask;
         OP_CLR:  new_row = row & ~mask;
         OP_TGL:  new_row = row ^ mask;
         default: new_row = '0;
      endcase
   end

endmodule

// File: rtl/frame_ram_arbiter.sv
// Single-port frame RAM owner: the display read path has absolute priority, game commands
// run as read-modify-write (or a full-screen clear) in the cycles the display leaves idle.
module frame_ram_arbiter
   import frame_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            disp_req,
   input  logic [AW-1:0]   disp_addr,
   output logic [COLS-1:0] disp_rdata,
   output logic            disp_valid,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [1:0]      cmd_op,
   input  logic [XW-1:0]   cmd_x,
   input  logic [AW-1:0]   cmd_y,
   output logic            cmd_done,
   output logic            cmd_err,
   output logic [AW-1:0]   ram_addr,
   output logic            ram_we,
   output logic [COLS-1:0] ram_wdata,
   input  logic [COLS-1:0] ram_rdata
);

   state_t          state_q, state_d;
   cmd_t            cmd_q, cmd_d;
   logic [COLS-1:0] row_q, row_d;
   logic [AW-1:0]   cnt_q, cnt_d;
   logic            done_d, err_d;
   logic            fsm_we;
   logic [AW-1:0]   fsm_addr;
   logic [COLS-1:0] fsm_wdata;
   logic [COLS-1:0] mod_row;

   row_bit_modify u_modify (
      .row     (ram_rdata),
      .idx     (cmd_q.x),
      .op      (cmd_q.op),
      .new_row (mod_row)
   );

   assign disp_rdata = ram_rdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cmd_q      <= '0;
         row_q      <= '0;
         cnt_q      <= '0;
         disp_valid <= 1'b0;
         cmd_done   <= 1'b0;
         cmd_err    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         row_q      <= row_d;
         cnt_q      <= cnt_d;
         disp_valid <= disp_req;
         cmd_done   <= done_d;
         cmd_err    <= err_d;
      end
   end

   // Next state and the FSM's view of the RAM port; the display overrides it below.
   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      row_d     = row_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      fsm_we    = 1'b0;
      fsm_addr  = cmd_q.y;
      fsm_wdata = '0;
      cmd_ready = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cmd_ready = ~rst;
            if (cmd_valid) begin
               cmd_d = '{op: cmd_op, x: cmd_x, y: cmd_y};
               if (cmd_op == OP_CLRALL) begin
                  state_d = ST_CLR;
                  cnt_d   = '0;
               end else if (cmd_x >= XW'(COLS)) begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end else begin
                  state_d = ST_RD;
               end
            end
         end
         ST_RD: begin
            if (!disp_req) state_d = ST_CAP;
         end
         // Read data here always belongs to the RD read, even if the display is asking now.
         ST_CAP: begin
            row_d   = mod_row;
            state_d = ST_WR;
         end
         ST_WR: begin
            fsm_wdata = row_q;
            if (!disp_req) begin
               fsm_we  = 1'b1;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_CLR: begin
            fsm_addr = cnt_q;
            if (!disp_req) begin
               fsm_we = 1'b1;
               cnt_d  = cnt_q + AW'(1);
               if (cnt_q == AW'(ROWS - 1)) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Display wins the port outright; reset forces an idle, all-zero port.
   always_comb begin
      ram_addr  = fsm_addr;
      ram_we    = fsm_we;
      ram_wdata = fsm_we ? fsm_wdata : '0;
      if (disp_req) begin
         ram_addr  = disp_addr;
         ram_we    = 1'b0;
         ram_wdata = '0;
      end
      if (rst) begin
         ram_addr  = '0;
         ram_we    = 1'b0;
         ram_wdata = '0;
      end
   end

endmodule
